// File: rtl/jh512_pkg.sv
// Shared definitions for the JH512 digest path.
//   JH512_HASH_W  : width of a complete JH512 digest in bits
//   JH512_BLOCK_W : widest word the digest reader may emit
//   jh512_state_e : two-state encoding used by the digest reader FSM
package jh512_pkg;

  localparam int JH512_HASH_W  = 512;
  localparam int JH512_BLOCK_W = 128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } jh512_state_e;

endpackage : jh512_pkg

// File: rtl/jh512_digest_reader.sv
// Serialises a 512-bit JH512 digest into WORD_W-bit words over a
// valid/ready stream. A digest is captured on a one-cycle hash_valid strobe
// and sent from a holding register that shifts by one word per handshake.
//
// Parameters
//   WORD_W    : output word width (8, 16, 32, 64 or 128)
//   MSB_FIRST : 1 = hash_in[511 -: WORD_W] first, 0 = hash_in[WORD_W-1:0] first
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   hash_in    : digest, sampled when hash_valid=1
//   hash_valid : one-cycle strobe marking hash_in as a final digest
//   out_data   : current digest word
//   out_valid  : out_data is valid
//   out_ready  : downstream accepts the word
//   out_last   : marks the final word of a digest
//   busy       : a digest is held and not fully sent
//   overrun    : sticky, a digest arrived while busy and was dropped
//   clr_ovr    : clears overrun (a simultaneous drop takes priority)
module jh512_digest_reader
  import jh512_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [JH512_HASH_W-1:0] hash_in,
  input  logic                    hash_valid,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_ovr
);

  localparam int N     = JH512_HASH_W / WORD_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (((JH512_HASH_W % WORD_W) != 0) || (WORD_W > JH512_BLOCK_W)) begin : g_bad_word_w
    $error("jh512_digest_reader: WORD_W must divide 512 and be at most 128");
  end

  jh512_state_e            state_q, state_d;
  logic [JH512_HASH_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    ovr_q, ovr_d;
  logic                    hs, final_hs, drop;

  // Move the next word into the output slot; vacated bits fill with zero.
  function automatic logic [JH512_HASH_W-1:0] shift_word(input logic [JH512_HASH_W-1:0] h);
    if (MSB_FIRST)
      return {h[JH512_HASH_W-WORD_W-1:0], {WORD_W{1'b0}}};
    else
      return {{WORD_W{1'b0}}, h[JH512_HASH_W-1:WORD_W]};
  endfunction

  always_comb begin
    hs       = (state_q == ST_SEND) && out_ready;
    final_hs = hs && last_q;
    // A new digest is only taken when the current one is finishing this cycle.
    drop     = hash_valid && (state_q == ST_SEND) && !final_hs;

    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    last_d  = last_q;

    if (state_q == ST_IDLE) begin
      if (hash_valid) begin
        state_d = ST_SEND;
        hold_d  = hash_in;
        idx_d   = '0;
        last_d  = (LAST_IDX == '0);
      end
    end else begin
      if (final_hs) begin
        idx_d  = '0;
        if (hash_valid) begin
          // Back-to-back digest: reload without leaving SEND.
          hold_d = hash_in;
          last_d = (LAST_IDX == '0);
        end else begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end else if (hs) begin
        hold_d = shift_word(hold_q);
        idx_d  = idx_q + IDX_W'(1);
        last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
      end
    end

    // Set wins over clear.
    ovr_d = (ovr_q && !clr_ovr) || drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = MSB_FIRST ? hold_q[JH512_HASH_W-1 -: WORD_W] : hold_q[WORD_W-1:0];
  assign out_valid = (state_q == ST_SEND);
  assign busy      = (state_q == ST_SEND);
  assign out_last  = last_q;
  assign overrun   = ovr_q;

endmodule : jh512_digest_reader

// File: tb/tb_jh512_digest_reader.sv
// Bench for jh512_digest_reader: a 32-bit MSB-first instance and a 64-bit
// LSB-first instance, each with a queue of expected {last, data} words.
module tb_jh512_digest_reader;

  localparam logic [31:0] A_BASE = 32'hA000_0000;
  localparam logic [31:0] G_BASE = 32'hB000_0000;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WORD_W=32, MSB_FIRST=1
  logic         a_rst_n = 1'b0, a_hv = 1'b0, a_ready = 1'b0, a_clr = 1'b0;
  logic [511:0] a_hash = '0;
  logic [31:0]  a_data;
  logic         a_valid, a_last, a_busy, a_ovr;

  // Instance B: WORD_W=64, MSB_FIRST=0
  logic         b_rst_n = 1'b0, b_hv = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
  logic [511:0] b_hash = '0;
  logic [63:0]  b_data;
  logic         b_valid, b_last, b_busy, b_ovr;

  jh512_digest_reader #(.WORD_W(32), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .hash_in(a_hash), .hash_valid(a_hv),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .out_last(a_last), .busy(a_busy), .overrun(a_ovr), .clr_ovr(a_clr)
  );

  jh512_digest_reader #(.WORD_W(64), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .hash_in(b_hash), .hash_valid(b_hv),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_last(b_last), .busy(b_busy), .overrun(b_ovr), .clr_ovr(b_clr)
  );

  int total = 0;
  int bad   = 0;
  logic [32:0] qa[$];
  logic [64:0] qb[$];

  // Digest whose 32-bit word k (MSB-first) is base+k.
  function automatic logic [511:0] mk(input logic [31:0] base);
    logic [511:0] h;
    h = '0;
    for (int k = 0; k < 16; k++) h[511-32*k -: 32] = base + 32'(k);
    return h;
  endfunction

  task automatic test_reset;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({a_valid, a_last, a_busy, a_ovr} !== 4'b0) begin
      bad++; $display("FAIL reset_a_ctrl got=%b want=0000", {a_valid, a_last, a_busy, a_ovr});
    end
    total++;
    if (a_data !== 32'h0) begin bad++; $display("FAIL reset_a_data got=%h want=0", a_data); end
    total++;
    if ({b_valid, b_last, b_busy, b_ovr} !== 4'b0) begin
      bad++; $display("FAIL reset_b_ctrl got=%b want=0000", {b_valid, b_last, b_busy, b_ovr});
    end
    total++;
    if (b_data !== 64'h0) begin bad++; $display("FAIL reset_b_data got=%h want=0", b_data); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL idle_a_valid got=%b want=0", a_valid); end
  endtask

  task automatic test_basic;
    logic [32:0] e;
    int cyc;
    for (int k = 0; k < 16; k++) qa.push_back({k == 15, A_BASE + 32'(k)});
    a_hash = mk(A_BASE); a_hv = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    a_hv = 1'b0;
    total++;
    if (a_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", a_valid); end
    cyc = 0;
    while (qa.size() > 0 && cyc < 200) begin
      total++;
      if (a_valid !== 1'b1) begin bad++; $display("FAIL basic_gap got=%b want=1", a_valid); end
      if (a_valid && a_ready) begin
        e = qa.pop_front();
        total++;
        if ({a_last, a_data} !== e) begin
          bad++; $display("FAIL basic_word got=%h want=%h", {a_last, a_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (qa.size() != 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0 left", qa.size()); qa.delete(); end
    total++;
    if ({a_valid, a_busy} !== 2'b00) begin
      bad++; $display("FAIL basic_end got=%b want=00", {a_valid, a_busy});
    end
  endtask

  task automatic test_backpressure;
    logic [32:0] e, prv;
    logic        prv_stall;
    int cyc, n;
    for (int k = 0; k < 16; k++) qa.push_back({k == 15, A_BASE + 32'(k)});
    a_hash = mk(A_BASE); a_hv = 1'b1;
    @(negedge clk);
    a_hv = 1'b0;
    cyc = 0; n = 0; prv_stall = 1'b0; prv = '0;
    while (qa.size() > 0 && cyc < 200) begin
      a_ready = (cyc % 3 == 0);
      if (prv_stall) begin
        total++;
        if ({a_last, a_data} !== prv) begin
          bad++; $display("FAIL bp_stable got=%h want=%h", {a_last, a_data}, prv);
        end
      end
      if (a_valid && a_ready) begin
        e = qa.pop_front(); n++;
        total++;
        if ({a_last, a_data} !== e) begin
          bad++; $display("FAIL bp_word got=%h want=%h", {a_last, a_data}, e);
        end
      end
      prv_stall = a_valid && !a_ready;
      prv = {a_last, a_data};
      @(negedge clk); cyc++;
    end
    total++;
    if (n != 16 || qa.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d want=16", n); qa.delete();
    end
    a_ready = 1'b1;
  endtask

  task automatic test_overrun;
    logic [32:0] e;
    logic did, checked;
    int cyc, n;
    for (int k = 0; k < 16; k++) qa.push_back({k == 15, A_BASE + 32'(k)});
    a_hash = mk(A_BASE); a_hv = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    a_hv = 1'b0;
    total++;
    if (a_ovr !== 1'b0) begin bad++; $display("FAIL ovr_initial got=%b want=0", a_ovr); end
    cyc = 0; n = 0; did = 1'b0; checked = 1'b0;
    while (qa.size() > 0 && cyc < 200) begin
      if (did && !checked) begin
        checked = 1'b1;
        total++;
        if (a_ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", a_ovr); end
      end
      a_hv = 1'b0;
      if (n == 5 && a_valid && !did) begin
        a_hv = 1'b1; a_hash = '1; did = 1'b1;
      end
      if (a_valid && a_ready) begin
        e = qa.pop_front(); n++;
        total++;
        if ({a_last, a_data} !== e) begin
          bad++; $display("FAIL ovr_word got=%h want=%h", {a_last, a_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    a_hv = 1'b0;
    total++;
    if (qa.size() != 0) begin bad++; $display("FAIL ovr_timeout got=%0d want=0 left", qa.size()); qa.delete(); end
    repeat (3) @(negedge clk);
    total++;
    if (a_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", a_ovr); end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    total++;
    if (a_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", a_ovr); end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e;
    int cyc, n;
    for (int k = 0; k < 16; k++) qa.push_back({k == 15, A_BASE + 32'(k)});
    for (int k = 0; k < 16; k++) qa.push_back({k == 15, G_BASE + 32'(k)});
    a_hash = mk(A_BASE); a_hv = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    a_hv = 1'b0;
    cyc = 0; n = 0;
    while (qa.size() > 0 && cyc < 200) begin
      a_hv = 1'b0;
      if (n == 15 && a_valid) begin a_hv = 1'b1; a_hash = mk(G_BASE); end
      total++;
      if (a_valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble got=%b want=1", a_valid); end
      if (a_valid && a_ready) begin
        e = qa.pop_front(); n++;
        total++;
        if ({a_last, a_data} !== e) begin
          bad++; $display("FAIL b2b_word got=%h want=%h", {a_last, a_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    a_hv = 1'b0;
    total++;
    if (qa.size() != 0) begin bad++; $display("FAIL b2b_timeout got=%0d want=0 left", qa.size()); qa.delete(); end
    total++;
    if ({a_ovr, a_valid} !== 2'b00) begin
      bad++; $display("FAIL b2b_end got=%b want=00", {a_ovr, a_valid});
    end
  endtask

  task automatic test_lsb_reset;
    logic [64:0] e;
    logic        seen;
    int cyc, n;
    for (int j = 0; j < 8; j++)
      qb.push_back({j == 7, A_BASE + 32'(14 - 2*j), A_BASE + 32'(15 - 2*j)});
    b_hash = mk(A_BASE); b_hv = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    b_hv = 1'b0;
    total++;
    if (b_data !== 64'hA000_000E_A000_000F) begin
      bad++; $display("FAIL lsb_first got=%h want=a000000ea000000f", b_data);
    end
    cyc = 0; n = 0;
    while (n < 4 && cyc < 50) begin
      if (b_valid && b_ready) begin
        e = qb.pop_front(); n++;
        total++;
        if ({b_last, b_data} !== e) begin
          bad++; $display("FAIL lsb_word got=%h want=%h", {b_last, b_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL lsb_timeout got=%0d want=4", n); end
    // Reset for one cycle mid-stream; a strobe during reset must be ignored.
    b_rst_n = 1'b0; b_hv = 1'b1; b_hash = mk(32'h1234_0000);
    @(negedge clk);
    b_rst_n = 1'b1; b_hv = 1'b0;
    qb.delete();
    total++;
    if ({b_valid, b_busy, b_last} !== 3'b000 || b_data !== 64'h0) begin
      bad++; $display("FAIL lsb_reset got=%b/%h want=000/0", {b_valid, b_busy, b_last}, b_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL lsb_leftover got=1 want=0"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_lsb_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_jh512_digest_reader
